// File: rtl/axis_pattern_source.sv
// AXI4-Stream RGB565 test-pattern frame source (bars, ramp, checker, solid).
// Optional horizontal scroll of ramp/checker: define AXIS_PATGEN_SCROLL_EN.
module axis_pattern_source #(
  parameter int H_ACTIVE         = 1024,
  parameter int V_ACTIVE         = 768,
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int AXIS_TUSER_WIDTH = 1,
  parameter int CHECKER_LOG2     = 3
) (
  input  logic                        axi_clk,
  input  logic                        axi_rst,
  input  logic                        enable,
  input  logic [1:0]                  pattern_sel,
  input  logic [15:0]                 solid_color,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [15:0]                 frame_count,
  output logic                        busy
);

  localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = ($clog2(BAR_W) > 0) ? $clog2(BAR_W) : 1;
  localparam int GW    = (XW < 8) ? XW : 8;
  localparam int CXI   = (CHECKER_LOG2 < XW) ? CHECKER_LOG2 : 0;
  localparam int CYI   = (CHECKER_LOG2 < YW) ? CHECKER_LOG2 : 0;
  localparam bit CX_OK = (CHECKER_LOG2 < XW);
  localparam bit CY_OK = (CHECKER_LOG2 < YW);

  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  state_t state, state_n;

  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [2:0]    bar_idx, idx_n;
  logic [BW-1:0] bar_cnt, cnt_n;
  logic [1:0]    pat, pat_n;
  logic [15:0]   solid, solid_n;
`ifdef AXIS_PATGEN_SCROLL_EN
  logic [15:0]   fc_s, fc_n;
`endif

  logic [15:0] pix_q, pix_n;
  logic        sof_q;
  logic        last_q;
  logic        valid_q;

  logic xfer, line_end, frame_end, fc_inc;
  logic first, adv, stop;

  assign xfer      = valid_q && m_axis_tready;
  assign line_end  = (x == X_LAST);
  assign frame_end = line_end && (y == Y_LAST);
  assign fc_inc    = xfer && frame_end;

  always_comb begin
    state_n = state;
    first   = 1'b0;
    adv     = 1'b0;
    stop    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable) begin
          state_n = S_STREAM;
          first   = 1'b1;
        end
      end
      S_STREAM: begin
        if (xfer) begin
          if (!frame_end) begin
            adv = 1'b1;
          end else if (enable) begin
            first = 1'b1;
          end else begin
            stop    = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Coordinates, bar position and per-frame settings of the next beat
  always_comb begin
    x_n     = x;
    y_n     = y;
    idx_n   = bar_idx;
    cnt_n   = bar_cnt;
    pat_n   = pat;
    solid_n = solid;
`ifdef AXIS_PATGEN_SCROLL_EN
    fc_n    = fc_s;
`endif
    if (first) begin
      x_n     = '0;
      y_n     = '0;
      idx_n   = '0;
      cnt_n   = '0;
      pat_n   = pattern_sel;
      solid_n = solid_color;
`ifdef AXIS_PATGEN_SCROLL_EN
      fc_n    = fc_inc ? frame_count + 16'd1 : frame_count;
`endif
    end else if (stop) begin
      x_n   = '0;
      y_n   = '0;
      idx_n = '0;
      cnt_n = '0;
    end else if (adv) begin
      if (line_end) begin
        x_n   = '0;
        y_n   = y + 1'b1;
        idx_n = '0;
        cnt_n = '0;
      end else begin
        x_n = x + 1'b1;
        if (bar_idx != 3'd7) begin
          if (bar_cnt == BAR_LAST) begin
            idx_n = bar_idx + 3'd1;
            cnt_n = '0;
          end else begin
            cnt_n = bar_cnt + 1'b1;
          end
        end
      end
    end
  end

  logic [XW-1:0] xe;
  logic [7:0]    g;
  logic          cx, cy;

  always_comb begin
`ifdef AXIS_PATGEN_SCROLL_EN
    xe = x_n + XW'(fc_n);
`else
    xe = x_n;
`endif
    g  = 8'(xe[GW-1:0]);
    cx = CX_OK ? xe[CXI] : 1'b0;
    cy = CY_OK ? y_n[CYI] : 1'b0;
    unique case (pat_n)
      2'd0: begin
        unique case (idx_n)
          3'd0:    pix_n = 16'hFFFF;
          3'd1:    pix_n = 16'hFFE0;
          3'd2:    pix_n = 16'h07FF;
          3'd3:    pix_n = 16'h07E0;
          3'd4:    pix_n = 16'hF81F;
          3'd5:    pix_n = 16'hF800;
          3'd6:    pix_n = 16'h001F;
          default: pix_n = 16'h0000;
        endcase
      end
      2'd1:    pix_n = {g[7:3], g[7:2], g[7:3]};
      2'd2:    pix_n = (cx ^ cy) ? 16'hFFFF : 16'h0000;
      default: pix_n = solid_n;
    endcase
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state       <= S_IDLE;
      x           <= '0;
      y           <= '0;
      bar_idx     <= '0;
      bar_cnt     <= '0;
      pat         <= '0;
      solid       <= '0;
`ifdef AXIS_PATGEN_SCROLL_EN
      fc_s        <= '0;
`endif
      pix_q       <= '0;
      sof_q       <= 1'b0;
      last_q      <= 1'b0;
      valid_q     <= 1'b0;
      frame_count <= '0;
      busy        <= 1'b0;
    end else begin
      state   <= state_n;
      x       <= x_n;
      y       <= y_n;
      bar_idx <= idx_n;
      bar_cnt <= cnt_n;
      pat     <= pat_n;
      solid   <= solid_n;
`ifdef AXIS_PATGEN_SCROLL_EN
      fc_s    <= fc_n;
`endif
      busy    <= (state_n == S_STREAM);
      // Output beat only changes on a load; a stalled beat holds
      if (first || adv) begin
        pix_q   <= pix_n;
        sof_q   <= (x_n == '0) && (y_n == '0);
        last_q  <= (x_n == X_LAST);
        valid_q <= 1'b1;
      end else if (stop) begin
        sof_q   <= 1'b0;
        last_q  <= 1'b0;
        valid_q <= 1'b0;
      end
      if (fc_inc) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  assign m_axis_tdata  = AXIS_TDATA_WIDTH'(pix_q);
  assign m_axis_tuser  = AXIS_TUSER_WIDTH'(sof_q);
  assign m_axis_tlast  = last_q;
  assign m_axis_tvalid = valid_q;

endmodule

// File: tb/tb_axis_pattern_source.sv
// Scoreboard bench for axis_pattern_source on a 16x4 frame.
// Expected beats are queued per frame and compared as the DUT transfers.
module tb_axis_pattern_source;

  localparam int H = 16;
  localparam int V = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  psel = 2'd0;
  logic [15:0] solid = 16'h0000;
  logic        tready = 1'b0;
  logic [15:0] tdata;
  logic [0:0]  tuser;
  logic        tlast;
  logic        tvalid;
  logic [15:0] fcount;
  logic        busy;

  axis_pattern_source #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .AXIS_TDATA_WIDTH(16),
    .AXIS_TUSER_WIDTH(1),
    .CHECKER_LOG2(3)
  ) dut (
    .axi_clk(clk),
    .axi_rst(rst),
    .enable(enable),
    .pattern_sel(psel),
    .solid_color(solid),
    .m_axis_tdata(tdata),
    .m_axis_tuser(tuser),
    .m_axis_tlast(tlast),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .frame_count(fcount),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        u;
    logic        l;
    logic [15:0] fc;
  } beat_t;

  localparam logic [15:0] BARS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  beat_t       q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          nxfer = 0;
  bit          rnd = 1'b0;
  bit          gapchk = 1'b0;
  bit          stall_v = 1'b0;
  logic [17:0] held;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input int pat, input logic [15:0] sc,
                                        input int x, input int y, input int fc);
    int         xe;
    int         bar;
    logic [7:0] g;
    xe = x;
`ifdef AXIS_PATGEN_SCROLL_EN
    xe = (x + fc) % H;
`endif
    g = 8'(xe);
    case (pat)
      0: begin
        bar = x / (H / 8);
        if (bar > 7) bar = 7;
        return BARS[bar];
      end
      1: return {g[7:3], g[7:2], g[7:3]};
      2: return ((((xe >> 3) ^ (y >> 3)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: return sc;
    endcase
  endfunction

  task automatic push_frame(input int pat, input logic [15:0] sc, input int fc);
    beat_t b;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        b.d  = model(pat, sc, x, y, fc);
        b.u  = (x == 0) && (y == 0);
        b.l  = (x == H - 1);
        b.fc = 16'(fc);
        q.push_back(b);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) tready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_q(input int lvl, input int bound);
    for (int i = 0; i < bound && q.size() > lvl; i++) tick();
    check("wait_q", q.size(), lvl);
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      stall_v = 1'b0;
    end else begin
      if (gapchk) check("no_gap", tvalid, 1);
      if (stall_v) begin
        check("hold_valid", tvalid, 1);
        check("hold_beat", {tdata, tuser, tlast}, held);
      end
      if (tvalid && tready) begin
        nxfer++;
        if (q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          e = q.pop_front();
          check("tdata", tdata, e.d);
          check("tuser", tuser, e.u);
          check("tlast", tlast, e.l);
          check("fcount", fcount, e.fc);
        end
      end
      stall_v = tvalid && !tready;
      held    = {tdata, tuser, tlast};
    end
  end

  initial begin
    int n0;
    @(negedge clk);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tuser", tuser, 0);
    check("rst_tlast", tlast, 0);
    check("rst_fcount", fcount, 0);
    check("rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    tready = 1'b1;
    tick();

    // Colour bars, two back-to-back frames, enable dropped in the second
    psel = 2'd0;
    push_frame(0, 16'h0, 0);
    push_frame(0, 16'h0, 1);
    enable = 1'b1;
    @(negedge clk);
    check("lat_idle", tvalid, 0);
    tick();
    @(negedge clk);
    check("lat_first", tvalid, 1);
    check("busy_on", busy, 1);
    gapchk = 1'b1;
    wait_q(54, 400);
    enable = 1'b0;
    wait_q(0, 400);
    gapchk = 1'b0;
    @(negedge clk);
    check("t1_tvalid_off", tvalid, 0);
    check("t1_busy_off", busy, 0);
    check("t1_fcount", fcount, 2);

    // Checkerboard with random backpressure, single frame
    tick();
    psel = 2'd2;
    rnd = 1'b1;
    n0 = nxfer;
    push_frame(2, 16'h0, 2);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_q(0, 4000);
    @(negedge clk);
    check("t2_count", nxfer - n0, 64);
    check("t2_tvalid_off", tvalid, 0);
    check("t2_fcount", fcount, 3);
    rnd = 1'b0;
    tick();
    tready = 1'b1;

    // Ramp, then pattern/colour changed mid-frame take effect next frame
    psel = 2'd1;
    solid = 16'h0000;
    push_frame(1, 16'h0, 3);
    push_frame(3, 16'hF800, 4);
    enable = 1'b1;
    wait_q(100, 400);
    psel = 2'd3;
    solid = 16'hF800;
    wait_q(60, 400);
    enable = 1'b0;
    wait_q(0, 400);
    @(negedge clk);
    check("t3_tvalid_off", tvalid, 0);
    check("t3_fcount", fcount, 5);

    // Reset asserted while stalled mid-frame
    tick();
    psel = 2'd0;
    push_frame(0, 16'h0, 5);
    n0 = nxfer;
    enable = 1'b1;
    for (int i = 0; i < 400 && (nxfer - n0) < 20; i++) tick();
    check("t4_reach20", nxfer - n0, 20);
    tready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("t4_rst_tvalid", tvalid, 0);
    check("t4_rst_fcount", fcount, 0);
    check("t4_rst_busy", busy, 0);
    tick();
    q.delete();
    push_frame(0, 16'h0, 0);
    tready = 1'b1;
    rst = 1'b0;
    wait_q(60, 400);
    enable = 1'b0;
    wait_q(0, 400);
    @(negedge clk);
    check("t4_tvalid_off", tvalid, 0);
    check("t4_fcount", fcount, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
